// File: rtl/prim_subreg_shadow_wr_ctrl_if.sv
// Bus-side bundle for the shadowed-register write front end.
// The slave modport is the controller; the master modport is the bus agent.
interface prim_subreg_shadow_wr_ctrl_if #(
    parameter int DW = 2
);
    logic          we_i;
    logic [DW-1:0] wd_i;
    logic          re_i;
    logic [DW-1:0] q_o;
    logic [DW-1:0] qs_o;
    logic          phase_o;
    logic          commit_o;
    logic          update_err_o;
    logic          storage_err_o;

    modport slave (
        input  we_i, wd_i, re_i,
        output q_o, qs_o, phase_o,
        output commit_o, update_err_o, storage_err_o
    );

    modport master (
        output we_i, wd_i, re_i,
        input  q_o, qs_o, phase_o,
        input  commit_o, update_err_o, storage_err_o
    );
endinterface

// File: rtl/prim_subreg_shadow_wr_ctrl.sv
// Two-phase write controller for a shadowed register: a value commits only
// after two identical consecutive writes; an inverted shadow copy guards it.
module prim_subreg_shadow_wr_ctrl #(
    parameter int            DW     = 2,
    parameter logic [DW-1:0] RESVAL = '0
) (
    input logic                           clk_i,
    input logic                           rst_ni,
    prim_subreg_shadow_wr_ctrl_if.slave   bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        STAGED = 1'b1
    } phase_e;

    phase_e        r_phase;
    logic [DW-1:0] r_staged;
    logic [DW-1:0] r_committed;
    logic [DW-1:0] r_shadow;
    logic          r_commit;
    logic          r_uerr;

    phase_e        w_phase_d;
    logic [DW-1:0] w_staged_d;
    logic [DW-1:0] w_committed_d;
    logic [DW-1:0] w_shadow_d;
    logic          w_commit_d;
    logic          w_uerr_d;
    logic          w_match;

    assign w_match = (bus.wd_i == r_staged);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_phase     <= IDLE;
            r_staged    <= RESVAL;
            r_committed <= RESVAL;
            r_shadow    <= ~RESVAL;
            r_commit    <= 1'b0;
            r_uerr      <= 1'b0;
        end else begin
            r_phase     <= w_phase_d;
            r_staged    <= w_staged_d;
            r_committed <= w_committed_d;
            r_shadow    <= w_shadow_d;
            r_commit    <= w_commit_d;
            r_uerr      <= w_uerr_d;
        end
    end

    // A write always takes priority over a read in the same cycle.
    always_comb begin
        w_phase_d     = r_phase;
        w_staged_d    = r_staged;
        w_committed_d = r_committed;
        w_shadow_d    = r_shadow;
        w_commit_d    = 1'b0;
        w_uerr_d      = 1'b0;
        unique case (r_phase)
            IDLE: begin
                if (bus.we_i) begin
                    w_staged_d = bus.wd_i;
                    w_phase_d  = STAGED;
                end
            end
            STAGED: begin
                if (bus.we_i) begin
                    w_phase_d = IDLE;
                    if (w_match) begin
                        w_committed_d = bus.wd_i;
                        w_shadow_d    = ~bus.wd_i;
                        w_commit_d    = 1'b1;
                    end else begin
                        w_staged_d = bus.wd_i;
                        w_uerr_d   = 1'b1;
                    end
                end else if (bus.re_i) begin
                    w_phase_d = IDLE;
                end
            end
            default: w_phase_d = IDLE;
        endcase
    end

    assign bus.q_o           = r_committed;
    assign bus.qs_o          = r_staged;
    assign bus.phase_o       = r_phase;
    assign bus.commit_o      = r_commit;
    assign bus.update_err_o  = r_uerr;
    assign bus.storage_err_o = |(r_committed ^ ~r_shadow);

endmodule

// File: tb/tb_prim_subreg_shadow_wr_ctrl.sv
// Directed bench for the shadowed-register write controller (DW=2, RESVAL=01).
module tb_prim_subreg_shadow_wr_ctrl;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    prim_subreg_shadow_wr_ctrl_if #(.DW(2)) bus ();

    prim_subreg_shadow_wr_ctrl #(
        .DW(2),
        .RESVAL(2'b01)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present inputs for one cycle, then sample #1 after the edge.
    task automatic cyc(input logic we, input logic [1:0] wd, input logic re);
        bus.we_i = we;
        bus.wd_i = wd;
        bus.re_i = re;
        @(posedge clk);
        #1;
        bus.we_i = 1'b0;
        bus.re_i = 1'b0;
        bus.wd_i = 2'b00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        bus.we_i = 1'b0;
        bus.wd_i = 2'b00;
        bus.re_i = 1'b0;
        rst_n    = 1'b1;
        #2;

        // Reset state
        do_reset();
        chk("rst_q", bus.q_o, 2'b01);
        chk("rst_qs", bus.qs_o, 2'b01);
        chk("rst_phase", bus.phase_o, 1'b0);
        chk("rst_commit", bus.commit_o, 1'b0);
        chk("rst_uerr", bus.update_err_o, 1'b0);
        chk("rst_serr", bus.storage_err_o, 1'b0);

        // Matching double write commits 10
        cyc(1'b1, 2'b10, 1'b0);
        chk("w1_phase", bus.phase_o, 1'b1);
        chk("w1_qs", bus.qs_o, 2'b10);
        chk("w1_q", bus.q_o, 2'b01);
        chk("w1_commit", bus.commit_o, 1'b0);
        cyc(1'b1, 2'b10, 1'b0);
        chk("w2_q", bus.q_o, 2'b10);
        chk("w2_commit", bus.commit_o, 1'b1);
        chk("w2_uerr", bus.update_err_o, 1'b0);
        chk("w2_phase", bus.phase_o, 1'b0);
        cyc(1'b0, 2'b00, 1'b0);
        chk("w2_commit_1cyc", bus.commit_o, 1'b0);
        chk("w2_q_hold", bus.q_o, 2'b10);

        // Mismatched confirm raises update error
        do_reset();
        cyc(1'b1, 2'b11, 1'b0);
        cyc(1'b1, 2'b00, 1'b0);
        chk("mm_uerr", bus.update_err_o, 1'b1);
        chk("mm_commit", bus.commit_o, 1'b0);
        chk("mm_q", bus.q_o, 2'b01);
        chk("mm_qs", bus.qs_o, 2'b00);
        chk("mm_phase", bus.phase_o, 1'b0);
        chk("mm_serr", bus.storage_err_o, 1'b0);
        cyc(1'b0, 2'b00, 1'b0);
        chk("mm_uerr_1cyc", bus.update_err_o, 1'b0);

        // Read aborts the pending first phase
        cyc(1'b1, 2'b11, 1'b0);
        chk("ab_phase1", bus.phase_o, 1'b1);
        cyc(1'b0, 2'b00, 1'b1);
        chk("ab_phase0", bus.phase_o, 1'b0);
        chk("ab_qs", bus.qs_o, 2'b11);
        chk("ab_commit", bus.commit_o, 1'b0);
        cyc(1'b1, 2'b11, 1'b0);
        chk("ab_new_phase", bus.phase_o, 1'b1);
        chk("ab_no_commit", bus.commit_o, 1'b0);
        chk("ab_q_hold", bus.q_o, 2'b01);
        cyc(1'b1, 2'b11, 1'b0);
        chk("ab_commit2", bus.commit_o, 1'b1);
        chk("ab_q11", bus.q_o, 2'b11);

        // Same-cycle write and read: write wins
        cyc(1'b1, 2'b10, 1'b0);
        cyc(1'b1, 2'b10, 1'b1);
        chk("wr_commit", bus.commit_o, 1'b1);
        chk("wr_q", bus.q_o, 2'b10);
        chk("wr_phase", bus.phase_o, 1'b0);

        // Third consecutive write starts a new first phase
        cyc(1'b1, 2'b00, 1'b0);
        chk("b2b_phase", bus.phase_o, 1'b1);
        chk("b2b_commit", bus.commit_o, 1'b0);

        // Async reset while staged
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_phase", bus.phase_o, 1'b0);
        chk("ar_q", bus.q_o, 2'b01);
        chk("ar_qs", bus.qs_o, 2'b01);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Corrupted shadow flags a sticky storage error
        force dut.r_shadow = 2'b11;
        #1;
        chk("se_set", bus.storage_err_o, 1'b1);
        cyc(1'b0, 2'b00, 1'b0);
        chk("se_hold", bus.storage_err_o, 1'b1);
        release dut.r_shadow;
        cyc(1'b0, 2'b00, 1'b0);
        chk("se_sticky", bus.storage_err_o, 1'b1);
        cyc(1'b1, 2'b10, 1'b0);
        chk("se_staged", bus.storage_err_o, 1'b1);
        cyc(1'b1, 2'b10, 1'b0);
        chk("se_commit", bus.commit_o, 1'b1);
        chk("se_clear", bus.storage_err_o, 1'b0);
        chk("se_q", bus.q_o, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
